// File: rtl/hash_arbiter_if.sv
// Requester-side and hash-core-side signal bundle for the shared hash core arbiter.
// Latency: none, wiring only.
// Backpressure: the core's rtr reaches the owning requester through the arbiter (master view).
interface hash_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8,
    parameter int HASH_W = 32
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_dr;
    logic [N_REQ-1:0]        req_eof;
    logic [N_REQ-1:0]        req_rtr;
    logic [N_REQ-1:0]        grant;
    logic [N_REQ-1:0]        digest_valid;
    logic [HASH_W-1:0]       digest;
    logic                    err;
    logic                    busy;
    logic                    core_start;
    logic                    core_case_rc0;
    logic [DATA_W-1:0]       core_data;
    logic                    core_dr;
    logic                    core_eof;
    logic                    core_rtr;
    logic                    core_h_ready;
    logic [HASH_W-1:0]       core_digest;

    modport master (
        input  req_valid, req_data, req_dr, req_eof,
        input  core_rtr, core_h_ready, core_digest,
        output req_rtr, grant, digest_valid, digest, err, busy,
        output core_start, core_case_rc0, core_data, core_dr, core_eof
    );

    modport slave (
        output req_valid, req_data, req_dr, req_eof,
        output core_rtr, core_h_ready, core_digest,
        input  req_rtr, grant, digest_valid, digest, err, busy,
        input  core_start, core_case_rc0, core_data, core_dr, core_eof
    );
endinterface

// File: rtl/hash_arbiter.sv
// Round-robin owner of one hash core: grants a requester per message, restarts the core, streams, returns the digest.
// Latency: grant 1 cycle after request sampled in IDLE, stream 2 cycles after; digest/digest_valid 1 cycle after core_h_ready.
// Backpressure: core_rtr passes combinationally to the owner's req_rtr only; non-owners wait until release.
module hash_arbiter #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8,
    parameter int HASH_W = 32,
    parameter int WD_MAX = 4096
) (
    input  logic           clk,
    input  logic           rst,
    hash_arbiter_if.master bus
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int WD_W  = $clog2(WD_MAX + 1);

    typedef enum logic [2:0] {IDLE, RESTART, STREAM, WAIT_H, DELIVER, ABORT} state_t;

    state_t           state;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] owner;
    logic [PTR_W-1:0] winner;
    logic [N_REQ-1:0] win_oh;
    logic [WD_W-1:0]  wd;
    logic             owner_valid;
    logic             owner_dr;
    logic             owner_eof;
    logic             msg_done;
    logic             abort_go;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] g);
        return (int'(g) == N_REQ - 1) ? '0 : g + PTR_W'(1);
    endfunction

    // Later offsets overwrite earlier ones, so the smallest offset from ptr wins.
    always_comb begin
        winner = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (bus.req_valid[i] && (((int'(ptr) + k) % N_REQ) == i)) begin
                    winner = PTR_W'(i);
                end
            end
        end
    end

    assign win_oh      = N_REQ'(1) << winner;
    assign owner_valid = |(bus.req_valid & bus.grant);
    assign owner_dr    = |(bus.req_dr & bus.grant);
    assign owner_eof   = |(bus.req_eof & bus.grant);
    assign msg_done    = owner_eof && bus.core_rtr && !owner_dr;

    // A digest arriving on the watchdog's last cycle is still delivered.
    assign abort_go = ((state == STREAM) && !owner_valid) ||
                      ((state == WAIT_H) && !bus.core_h_ready &&
                       (!owner_valid || (wd == WD_W'(WD_MAX - 1))));

    always_comb begin
        bus.core_data = '0;
        bus.core_dr   = 1'b0;
        bus.core_eof  = 1'b0;
        bus.req_rtr   = '0;
        if (state == STREAM) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (owner == PTR_W'(i)) begin
                    bus.core_data = bus.req_data[i*DATA_W +: DATA_W];
                end
            end
            bus.core_dr  = owner_dr;
            bus.core_eof = owner_eof;
            bus.req_rtr  = bus.grant & {N_REQ{bus.core_rtr}};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            ptr               <= '0;
            owner             <= '0;
            wd                <= '0;
            bus.grant         <= '0;
            bus.digest_valid  <= '0;
            bus.digest        <= '0;
            bus.err           <= 1'b0;
            bus.busy          <= 1'b0;
            bus.core_start    <= 1'b0;
            bus.core_case_rc0 <= 1'b0;
        end else begin
            bus.core_start    <= 1'b0;
            bus.core_case_rc0 <= 1'b0;
            bus.err           <= 1'b0;
            bus.digest_valid  <= '0;
            if (abort_go) begin
                state             <= ABORT;
                bus.err           <= 1'b1;
                bus.core_start    <= 1'b1;
                bus.core_case_rc0 <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (|bus.req_valid) begin
                            owner             <= winner;
                            bus.grant         <= win_oh;
                            bus.busy          <= 1'b1;
                            bus.core_start    <= 1'b1;
                            bus.core_case_rc0 <= 1'b1;
                            state             <= RESTART;
                        end
                    end
                    RESTART: state <= STREAM;
                    STREAM: begin
                        if (msg_done) begin
                            wd    <= '0;
                            state <= WAIT_H;
                        end
                    end
                    WAIT_H: begin
                        if (wd != WD_W'(WD_MAX)) begin
                            wd <= wd + WD_W'(1);
                        end
                        if (bus.core_h_ready) begin
                            bus.digest       <= bus.core_digest;
                            bus.digest_valid <= bus.grant;
                            state            <= DELIVER;
                        end
                    end
                    DELIVER, ABORT: begin
                        bus.grant <= '0;
                        bus.busy  <= 1'b0;
                        ptr       <= next_ptr(owner);
                        state     <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_hash_arbiter.sv
// Randomized bench for hash_arbiter against a message-level round-robin model.
// Latency: n/a. Backpressure: core_rtr is randomly stalled during streaming.
// Inputs change 1 time unit after the rising edge; outputs are sampled after that.
module tb_hash_arbiter;
    localparam int N      = 4;
    localparam int DW     = 8;
    localparam int HW     = 32;
    localparam int WD_MAX = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hash_arbiter_if #(.N_REQ(N), .DATA_W(DW), .HASH_W(HW)) bus ();

    hash_arbiter #(.N_REQ(N), .DATA_W(DW), .HASH_W(HW), .WD_MAX(WD_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_chk  = 0;
    int          n_err  = 0;
    int          m_ptr  = 0;
    logic [31:0] m_dig  = '0;
    logic [N-1:0] pend  = '0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Owner choice straight from the rule: first pending index at or after ptr, wrapping.
    function automatic int rr_pick(input logic [N-1:0] p, input int start);
        for (int k = 0; k < N; k++) begin
            if (p[(start + k) % N]) return (start + k) % N;
        end
        return 0;
    endfunction

    task automatic noise();
        bus.req_data = $urandom;
        bus.req_dr   = N'($urandom);
        bus.req_eof  = N'($urandom);
    endtask

    function automatic logic [63:0] all_outs();
        return {6'd0, bus.grant, bus.req_rtr, bus.digest_valid, bus.digest, bus.err, bus.busy,
                bus.core_start, bus.core_case_rc0, bus.core_dr, bus.core_eof, bus.core_data};
    endfunction

    // mode: 0 normal, 1 watchdog, 2 owner drops mid-stream, 3 reset in WAIT_H
    task automatic run_msg(input int nwords, input int mode, input bit both,
                           input int hdly, input logic [31:0] dg);
        int   w;
        int   sent;
        int   seen;
        int   tries;
        bit   r;
        logic [DW-1:0] word;
        w = rr_pick(pend, m_ptr);
        bus.req_valid = pend;
        tick();
        check_eq("grant", bus.grant, 64'd1 << w);
        check_eq("restart", {bus.core_start, bus.core_case_rc0}, 2'b11);
        check_eq("busy", bus.busy, 1);
        tick();
        check_eq("start_pulse", bus.core_start, 0);
        sent = 0;
        seen = 0;
        while (sent < nwords) begin
            if (mode == 2 && sent == nwords / 2) begin
                pend[w] = 1'b0;
                bus.req_valid = pend;
                tick();
                check_eq("abort_err", {bus.err, bus.core_start, bus.core_case_rc0}, 3'b111);
                check_eq("abort_dig", {bus.digest_valid, bus.digest}, {4'd0, m_dig});
                tick();
                check_eq("abort_rel", {bus.grant, bus.busy, bus.err}, 0);
                m_ptr = (w + 1) % N;
                return;
            end
            noise();
            word = DW'($urandom);
            bus.req_data[w*DW +: DW] = word;
            bus.req_dr[w]  = 1'b1;
            bus.req_eof[w] = both && (sent == nwords - 1);
            r = ($urandom_range(0, 2) != 0);
            bus.core_rtr = r;
            #1;
            check_eq("core_data", bus.core_data, word);
            check_eq("core_dr", bus.core_dr, 1);
            check_eq("rtr_route", bus.req_rtr, r ? (64'd1 << w) : 64'd0);
            check_eq("grant_excl", bus.grant, 64'd1 << w);
            if (bus.core_dr && bus.core_rtr) seen++;
            if (r) sent++;
            tick();
        end
        tries = 0;
        do begin
            noise();
            bus.req_dr[w]  = 1'b0;
            bus.req_eof[w] = 1'b1;
            r = (tries > 6) ? 1'b1 : 1'($urandom_range(0, 1));
            bus.core_rtr = r;
            tries++;
            #1;
            check_eq("eof_pass", {bus.core_eof, bus.core_dr}, 2'b10);
            check_eq("eof_rtr", bus.req_rtr, r ? (64'd1 << w) : 64'd0);
            tick();
        end while (!r);
        check_eq("xfer_count", seen, nwords);
        noise();
        bus.core_rtr = 1'b1;
        bus.core_h_ready = 1'b0;
        #1;
        check_eq("wait_gate", {bus.core_dr, bus.core_eof, bus.core_data, bus.req_rtr, bus.err}, 0);
        if (mode == 3) begin
            rst = 1'b1;
            #1;
            check_eq("rst_outs", all_outs(), 0);
            tick();
            rst = 1'b0;
            m_ptr = 0;
            m_dig = '0;
            return;
        end
        if (mode == 1) begin
            for (int i = 1; i < WD_MAX; i++) begin
                tick();
                check_eq("wd_quiet", {bus.err, bus.digest_valid}, 0);
            end
            tick();
            check_eq("wd_err", {bus.err, bus.core_start, bus.core_case_rc0}, 3'b111);
            check_eq("wd_nodig", {bus.digest_valid, bus.digest}, {4'd0, m_dig});
            pend[w] = 1'b0;
            bus.req_valid = pend;
            tick();
            check_eq("wd_rel", {bus.grant, bus.busy, bus.err}, 0);
            m_ptr = (w + 1) % N;
            return;
        end
        for (int i = 0; i < hdly; i++) tick();
        bus.core_h_ready = 1'b1;
        bus.core_digest  = dg;
        tick();
        bus.core_h_ready = 1'b0;
        check_eq("digest", bus.digest, dg);
        check_eq("dig_valid", {bus.digest_valid, bus.err}, {4'(1 << w), 1'b0});
        m_dig = dg;
        pend[w] = 1'b0;
        bus.req_valid = pend;
        tick();
        check_eq("release", {bus.digest_valid, bus.grant, bus.busy}, 0);
        check_eq("dig_hold", bus.digest, m_dig);
        m_ptr = (w + 1) % N;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within bound");
        $fatal(1);
    end

    initial begin
        bus.req_valid    = '0;
        bus.req_data     = '0;
        bus.req_dr       = '0;
        bus.req_eof      = '0;
        bus.core_rtr     = 1'b0;
        bus.core_h_ready = 1'b0;
        bus.core_digest  = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check_eq("reset_state", all_outs(), 0);

        pend = 4'b0010;
        run_msg(3, 0, 1'b0, 2, 32'hDEADBEEF);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_ptr = 0;
        m_dig = '0;
        pend = 4'b1111;
        for (int i = 0; i < 4; i++) run_msg(2, 0, 1'b0, 1, $urandom);
        pend[0] = 1'b1;
        run_msg(1, 0, 1'b0, 0, $urandom);

        pend = 4'b0100;
        run_msg(2, 0, 1'b1, 3, $urandom);

        pend = 4'b1011;
        run_msg(2, 1, 1'b0, 0, '0);
        run_msg(2, 0, 1'b0, WD_MAX - 1, $urandom);

        run_msg(4, 2, 1'b0, 0, '0);

        for (int it = 0; it < 24; it++) begin
            int mode;
            pend = pend | N'($urandom_range(1, 15));
            mode = $urandom_range(0, 9);
            mode = (mode < 7) ? 0 : (mode == 7) ? 1 : 2;
            run_msg($urandom_range(1, 6), mode, 1'($urandom_range(0, 1)),
                    $urandom_range(0, WD_MAX - 1), $urandom);
        end

        pend = 4'b0110;
        run_msg(2, 3, 1'b0, 0, '0);
        pend = 4'b1111;
        run_msg(1, 0, 1'b0, 0, $urandom);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
